// File: rtl/minisys_pkg.sv
// Shared minisys definitions: arbiter FSM encoding and port-owner constants.
package minisys_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant select: on a tie the port not last served wins.
module rr_pick2
  import minisys_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_served,
  output logic winner
);

  always_comb begin
    if (cpu_req && dma_req) begin
      winner = ~last_served;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end else begin
      winner = OWN_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter in front of a single-port synchronous data RAM; two cycles per transaction
// with a bounded burst length whenever the other port is waiting.
module dmem_arbiter
  import minisys_pkg::*;
#(
  parameter int unsigned AW        = 14,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          prst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [31:0]   cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_ack,
  output logic [31:0]   dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          owner
);

  localparam logic [3:0] BurstLim = 4'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       pick;
  logic       own_req, oth_req;

  rr_pick2 u_pick (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_served (last_q),
    .winner      (pick)
  );

  assign own_req = (owner_q == OWN_DMA) ? dma_req : cpu_req;
  assign oth_req = (owner_q == OWN_DMA) ? cpu_req : dma_req;
  assign owner   = owner_q;

  always_ff @(posedge clock or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DMA;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = ACCESS;
          owner_d     = pick;
          burst_cnt_d = 4'd0;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        last_d = owner_q;
        // Owner keeps the RAM unless the other side waits and the burst budget is spent.
        if (own_req && (!oth_req || (burst_cnt_q < BurstLim))) begin
          state_d     = ACCESS;
          burst_cnt_d = (burst_cnt_q == 4'hf) ? burst_cnt_q : burst_cnt_q + 4'd1;
        end else if (oth_req) begin
          state_d     = ACCESS;
          owner_d     = ~owner_q;
          burst_cnt_d = 4'd0;
        end else begin
          state_d     = IDLE;
          burst_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    dma_ack   = 1'b0;
    dma_rdata = '0;
    if (state_q == ACCESS) begin
      mem_addr  = (owner_q == OWN_DMA) ? dma_addr  : cpu_addr;
      mem_wdata = (owner_q == OWN_DMA) ? dma_wdata : cpu_wdata;
      mem_we    = (owner_q == OWN_DMA) ? dma_we    : cpu_we;
    end else if (state_q == RESP) begin
      if (owner_q == OWN_DMA) begin
        dma_ack   = 1'b1;
        dma_rdata = mem_rdata;
      end else begin
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
      end
    end
  end

endmodule
